// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache refill/store engine.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FILL,
    DONE
  } state_t;

  // req_size[1:0] encodings; req_size[SZ_UNS] selects zero-extension on loads
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int         SZ_UNS = 2;

  // Byte lanes covered by an access of the given size, before offset shift
  function automatic logic [7:0] size_mask(input logic [2:0] size);
    size_mask = {{4{size[1] & size[0]}}, {2{size[1]}}, size[1] | size[0], 1'b1};
  endfunction

  // Sign/zero-extend an LSB-aligned load value to 64 bits
  function automatic logic [63:0] extend(input logic [63:0] tmp, input logic [2:0] size);
    logic sgn;
    sgn = ~size[SZ_UNS];
    case (size[1:0])
      SZ_B:    extend = {{56{sgn & tmp[7]}}, tmp[7:0]};
      SZ_H:    extend = {{48{sgn & tmp[15]}}, tmp[15:0]};
      SZ_W:    extend = {{32{sgn & tmp[31]}}, tmp[31:0]};
      SZ_D:    extend = tmp;
      default: extend = tmp;
    endcase
  endfunction

endpackage

// File: rtl/dcache_refill_if.sv
// System bus seen by the refill engine: one request channel, one response strobe.
interface dcache_refill_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wstrb;
  logic              rsp_valid;
  logic [63:0]       rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dcache_extend.sv
// Shift an aligned 64-bit word down to the access offset and extend it.
// Shared with the cache read-hit path.
module dcache_extend
  import dcache_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  offset,
  input  logic [2:0]  size,
  output logic [63:0] result
);

  logic [63:0] shifted;

  // Byte-lane shift then extension by size/unsigned bit
  always_comb begin
    shifted = data >> {offset, 3'b000};
    result  = extend(shifted, size);
  end

endmodule

// File: rtl/dcache_refill.sv
// Memory-side miss/store engine for the direct-mapped data cache.
//
//  state | meaning
//  IDLE  | waiting for a pipeline request
//  REQ   | bus request presented, fields held until ready
//  WAIT  | request accepted, waiting for the response strobe
//  FILL  | one-cycle cache update (fill on load, invalidate on store)
//  DONE  | one-cycle completion pulse, stall already released
module dcache_refill
  import dcache_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_W         = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [7:0]        req_mask,
  input  logic [63:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [63:0]       rdata,
  dcache_refill_if.master   bus,
  output logic              update,
  output logic              update_load,
  output logic [63:0]       update_data
);

  // Down-counter loaded with TIMEOUT_CYCLES-1 so that terminal count (0)
  // lands on the last allowed REQ/WAIT cycle.
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD =
    (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t            state;
  logic              load_q;
  logic [2:0]        offset_q;
  logic [2:0]        size_q;
  logic [63:0]       rsp_q;
  logic              flush_seen;
  logic [TMR_W-1:0]  tmr;
  logic              stall_q;
  logic              done_q;
  logic              err_q;
  logic [63:0]       rdata_q;
  logic              update_q;
  logic              update_load_q;
  logic [63:0]       update_data_q;
  logic              breq_valid_q;
  logic [ADDR_W-1:0] breq_addr_q;
  logic              breq_write_q;
  logic [63:0]       breq_wdata_q;
  logic [7:0]        breq_wstrb_q;
  logic [63:0]       ext_data;
  logic              timed_out;

  dcache_extend u_extend (
    .data   (rsp_q),
    .offset (offset_q),
    .size   (size_q),
    .result (ext_data)
  );

  assign timed_out = (TIMEOUT_CYCLES != 0) && (tmr == '0);

  // Transaction sequencer; every output below is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      load_q        <= 1'b0;
      offset_q      <= '0;
      size_q        <= '0;
      rsp_q         <= '0;
      flush_seen    <= 1'b0;
      tmr           <= '0;
      stall_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      update_q      <= 1'b0;
      update_load_q <= 1'b0;
      update_data_q <= '0;
      breq_valid_q  <= 1'b0;
      breq_addr_q   <= '0;
      breq_write_q  <= 1'b0;
      breq_wdata_q  <= '0;
      breq_wstrb_q  <= '0;
    end else begin
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      update_q      <= 1'b0;
      update_load_q <= 1'b0;
      if (state != IDLE && flush) flush_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (req_valid) begin
            load_q       <= req_load;
            offset_q     <= req_addr[2:0];
            size_q       <= req_size;
            flush_seen   <= flush;
            tmr          <= TMR_LOAD;
            stall_q      <= 1'b1;
            breq_valid_q <= 1'b1;
            breq_addr_q  <= {req_addr[ADDR_W-1:3], 3'b000};
            breq_write_q <= ~req_load;
            breq_wdata_q <= req_wdata << {req_addr[2:0], 3'b000};
            breq_wstrb_q <= (req_mask & size_mask(req_size)) << req_addr[2:0];
            state        <= REQ;
          end
        end

        REQ: begin
          if (timed_out) begin
            breq_valid_q <= 1'b0;
            stall_q      <= 1'b0;
            done_q       <= 1'b1;
            err_q        <= 1'b1;
            state        <= DONE;
          end else begin
            if (tmr != '0) tmr <= tmr - 1'b1;
            if (bus.req_ready) begin
              breq_valid_q <= 1'b0;
              state        <= WAIT;
            end
          end
        end

        WAIT: begin
          if (timed_out) begin
            stall_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state   <= DONE;
          end else begin
            if (tmr != '0) tmr <= tmr - 1'b1;
            if (bus.rsp_valid) begin
              rsp_q <= bus.rsp_data;
              if (bus.rsp_err) begin
                stall_q <= 1'b0;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
                state   <= DONE;
              end else begin
                // A load fill is dropped if the cache was invalidated meanwhile;
                // a store still invalidates its line.
                update_q      <= ~(load_q & (flush_seen | flush));
                update_load_q <= load_q & ~(flush_seen | flush);
                update_data_q <= load_q ? bus.rsp_data : 64'd0;
                state         <= FILL;
              end
            end
          end
        end

        FILL: begin
          stall_q <= 1'b0;
          done_q  <= 1'b1;
          rdata_q <= load_q ? ext_data : 64'd0;
          state   <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Stall covers the accept cycle combinationally, then the registered hold
  assign stall = stall_q | ((state == IDLE) & req_valid);

  // A flush coinciding with the fill cycle still kills a load fill
  assign update      = update_q & ~(update_load_q & flush);
  assign update_load = update_load_q & ~flush;
  assign update_data = update_data_q;

  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

  assign bus.req_valid = breq_valid_q;
  assign bus.req_addr  = breq_addr_q;
  assign bus.req_write = breq_write_q;
  assign bus.req_wdata = breq_wdata_q;
  assign bus.req_wstrb = breq_wstrb_q;

endmodule

// File: tb/tb_dcache_refill.sv
// Directed bench for dcache_refill with a scripted bus slave and a passive monitor.
module tb_dcache_refill;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_load;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_mask;
  logic [63:0] req_wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [63:0] rdata;
  logic        update;
  logic        update_load;
  logic [63:0] update_data;

  dcache_refill_if #(.ADDR_W(64)) bus ();

  dcache_refill #(.TIMEOUT_CYCLES(8), .ADDR_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_load    (req_load),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_mask    (req_mask),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .bus         (bus),
    .update      (update),
    .update_load (update_load),
    .update_data (update_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // monitor state, written only by the monitor process
  int           stall_cnt = 0, upd_cnt = 0, done_cnt = 0, breq_cnt = 0, unstable_cnt = 0;
  logic         upd_load_cap = 1'b0;
  logic [63:0]  upd_data_cap = '0;
  logic         err_cap = 1'b0;
  logic [63:0]  rdata_cap = '0;
  logic         valid_at_done = 1'b0;
  logic [63:0]  cap_addr = '0, cap_wdata = '0;
  logic [7:0]   cap_wstrb = '0;
  logic         cap_write = 1'b0;
  logic         prev_valid = 1'b0;
  logic [136:0] prev_fields = '0;

  // per-transaction deltas, written only by the main process
  int   d_stall, d_upd, d_done, d_breq, d_unstable;
  logic stall_at_accept;

  // Sample DUT outputs mid-cycle
  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (update) begin
      upd_cnt++;
      upd_load_cap = update_load;
      upd_data_cap = update_data;
    end
    if (done) begin
      done_cnt++;
      err_cap       = err;
      rdata_cap     = rdata;
      valid_at_done = bus.req_valid;
    end
    if (bus.req_valid) begin
      breq_cnt++;
      if (prev_valid &&
          prev_fields != {bus.req_addr, bus.req_wdata, bus.req_wstrb, bus.req_write})
        unstable_cnt++;
      cap_addr    = bus.req_addr;
      cap_wdata   = bus.req_wdata;
      cap_wstrb   = bus.req_wstrb;
      cap_write   = bus.req_write;
      prev_fields = {bus.req_addr, bus.req_wdata, bus.req_wstrb, bus.req_write};
    end
    prev_valid = bus.req_valid;
  end

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flush_mode: 0 none, 1 first WAIT cycle, 2 FILL cycle
  task automatic run_txn(input logic load, input logic [63:0] addr, input logic [2:0] size,
                         input logic [7:0] mask, input logic [63:0] wdata,
                         input int ready_delay, input int rsp_delay,
                         input logic [63:0] rsp_data, input logic rsp_err,
                         input logic respond, input int flush_mode);
    int s0, u0, d0, b0, x0;
    s0 = stall_cnt; u0 = upd_cnt; d0 = done_cnt; b0 = breq_cnt; x0 = unstable_cnt;
    req_valid = 1'b1;
    req_load  = load;
    req_addr  = addr;
    req_size  = size;
    req_mask  = mask;
    req_wdata = wdata;
    #1 stall_at_accept = stall;
    tick();
    req_valid = 1'b0;
    repeat (ready_delay) tick();
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    for (int i = 1; i <= rsp_delay; i++) begin
      if (flush_mode == 1 && i == 1) flush = 1'b1;
      if (respond && i == rsp_delay) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = rsp_data;
        bus.rsp_err   = rsp_err;
      end
      tick();
      flush         = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 1'b0;
    end
    if (flush_mode == 2) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
    tick();
    d_stall    = stall_cnt - s0;
    d_upd      = upd_cnt - u0;
    d_done     = done_cnt - d0;
    d_breq     = breq_cnt - b0;
    d_unstable = unstable_cnt - x0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_load = 1'b0;
    req_addr = '0; req_size = '0; req_mask = '0; req_wdata = '0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0; bus.rsp_err = 1'b0;
    repeat (3) tick();
    chk_val("rst_stall", stall, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_err", err, 0);
    chk_val("rst_rdata", rdata, 0);
    chk_val("rst_update", update, 0);
    chk_val("rst_update_data", update_data, 0);
    chk_val("rst_bus_valid", bus.req_valid, 0);
    chk_val("rst_bus_wstrb", bus.req_wstrb, 0);
    rst_n = 1'b1;
    tick();

    // load D, response on the 2nd WAIT cycle
    run_txn(1, 64'h1000, 3'b011, 8'hFF, 0, 0, 2, 64'h1122334455667788, 0, 1, 0);
    chk_val("ld_d_stall_comb", stall_at_accept, 1);
    chk_val("ld_d_stall_cycles", d_stall, 5);
    chk_val("ld_d_bus_addr", cap_addr, 64'h1000);
    chk_val("ld_d_bus_write", cap_write, 0);
    chk_val("ld_d_upd_cnt", d_upd, 1);
    chk_val("ld_d_upd_load", upd_load_cap, 1);
    chk_val("ld_d_upd_data", upd_data_cap, 64'h1122334455667788);
    chk_val("ld_d_done_cnt", d_done, 1);
    chk_val("ld_d_err", err_cap, 0);
    chk_val("ld_d_rdata", rdata_cap, 64'h1122334455667788);

    // byte/half/word extraction, minimum latency
    run_txn(1, 64'h1003, 3'b000, 8'hFF, 0, 0, 1, 64'h00000000_80FF0000, 0, 1, 0);
    chk_val("lb_stall_cycles", d_stall, 4);
    chk_val("lb_rdata", rdata_cap, 64'hFFFFFFFFFFFFFF80);
    run_txn(1, 64'h1003, 3'b100, 8'hFF, 0, 0, 1, 64'h00000000_80FF0000, 0, 1, 0);
    chk_val("lbu_rdata", rdata_cap, 64'h80);
    run_txn(1, 64'h1002, 3'b001, 8'hFF, 0, 0, 1, 64'h00000000_80FF0000, 0, 1, 0);
    chk_val("lh_rdata", rdata_cap, 64'hFFFFFFFFFFFF80FF);
    run_txn(1, 64'h1004, 3'b110, 8'hFF, 0, 0, 1, 64'h89ABCDEF_00000000, 0, 1, 0);
    chk_val("lwu_rdata", rdata_cap, 64'h0000000089ABCDEF);
    run_txn(1, 64'h1004, 3'b010, 8'hFF, 0, 0, 1, 64'h89ABCDEF_00000000, 0, 1, 0);
    chk_val("lw_rdata", rdata_cap, 64'hFFFFFFFF89ABCDEF);

    // stores: lane placement and invalidate pulse
    run_txn(0, 64'h2006, 3'b001, 8'hFF, 64'hBEEF, 0, 1, 0, 0, 1, 0);
    chk_val("sh_bus_addr", cap_addr, 64'h2000);
    chk_val("sh_bus_wstrb", cap_wstrb, 8'hC0);
    chk_val("sh_bus_wdata", cap_wdata, 64'hBEEF000000000000);
    chk_val("sh_bus_write", cap_write, 1);
    chk_val("sh_upd_cnt", d_upd, 1);
    chk_val("sh_upd_load", upd_load_cap, 0);
    chk_val("sh_rdata", rdata_cap, 0);
    chk_val("sh_err", err_cap, 0);
    run_txn(0, 64'h3006, 3'b010, 8'hFF, 64'h11223344, 0, 1, 0, 0, 1, 0);
    chk_val("sw_trunc_wstrb", cap_wstrb, 8'hC0);
    chk_val("sw_trunc_wdata", cap_wdata, 64'h3344000000000000);
    run_txn(0, 64'h4001, 3'b001, 8'hFE, 64'hA5A5, 0, 1, 0, 0, 1, 0);
    chk_val("sh_mask_wstrb", cap_wstrb, 8'h04);

    // ready held low 3 cycles, then error response
    run_txn(1, 64'h5008, 3'b011, 8'hFF, 0, 3, 1, 64'hDEAD, 1, 1, 0);
    chk_val("busy_req_cycles", d_breq, 4);
    chk_val("busy_unstable", d_unstable, 0);
    chk_val("busy_bus_addr", cap_addr, 64'h5008);
    chk_val("rsp_err_done", d_done, 1);
    chk_val("rsp_err_err", err_cap, 1);
    chk_val("rsp_err_upd_cnt", d_upd, 0);

    // flush during WAIT and during FILL suppresses a load fill
    run_txn(1, 64'h1000, 3'b011, 8'hFF, 0, 0, 2, 64'hCAFEF00D12345678, 0, 1, 1);
    chk_val("flush_wait_upd_cnt", d_upd, 0);
    chk_val("flush_wait_done", d_done, 1);
    chk_val("flush_wait_err", err_cap, 0);
    chk_val("flush_wait_rdata", rdata_cap, 64'hCAFEF00D12345678);
    run_txn(1, 64'h1000, 3'b011, 8'hFF, 0, 0, 1, 64'h0123456789ABCDEF, 0, 1, 2);
    chk_val("flush_fill_upd_cnt", d_upd, 0);
    chk_val("flush_fill_rdata", rdata_cap, 64'h0123456789ABCDEF);
    run_txn(0, 64'h6000, 3'b011, 8'hFF, 64'h77, 0, 2, 0, 0, 1, 1);
    chk_val("flush_store_upd_cnt", d_upd, 1);

    // timeout: no response, then no ready
    run_txn(1, 64'h7000, 3'b011, 8'hFF, 0, 0, 1, 0, 0, 0, 0);
    chk_val("to_rsp_done", d_done, 1);
    chk_val("to_rsp_err", err_cap, 1);
    chk_val("to_rsp_stall_cycles", d_stall, 9);
    chk_val("to_rsp_upd_cnt", d_upd, 0);
    chk_val("to_rsp_rdata", rdata_cap, 0);
    run_txn(1, 64'h7000, 3'b011, 8'hFF, 0, 12, 1, 0, 0, 0, 0);
    chk_val("to_rdy_req_cycles", d_breq, 8);
    chk_val("to_rdy_err", err_cap, 1);
    chk_val("to_rdy_valid_at_done", valid_at_done, 0);

    // reset in the middle of WAIT
    req_valid = 1'b1; req_load = 1'b1; req_addr = 64'h1000; req_size = 3'b011; req_mask = 8'hFF;
    tick();
    req_valid = 1'b0;
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_val("mid_rst_stall", stall, 0);
    chk_val("mid_rst_done", done, 0);
    chk_val("mid_rst_bus_valid", bus.req_valid, 0);
    chk_val("mid_rst_update", update, 0);
    chk_val("mid_rst_update_data", update_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_txn(1, 64'h1003, 3'b100, 8'hFF, 0, 0, 1, 64'h00000000_80FF0000, 0, 1, 0);
    chk_val("post_rst_done", d_done, 1);
    chk_val("post_rst_rdata", rdata_cap, 64'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_refill.md
Name: dcache_refill

Overview:
- Miss/store engine on the memory side of the direct-mapped data cache: the other end of the cache's update port.
- On a load miss it fetches the aligned 64-bit word over the system bus, then pulses the cache update port with the fill data, and returns the extracted, sign/zero-extended load result to the pipeline.
- On a store it writes the word through to the bus with byte strobes, then pulses update with opcode=store so the cache invalidates the stale line.
- It stalls the pipeline for the whole transaction.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles in REQ+WAIT before abort with error; 0 disables the timeout.
- ADDR_W, 64: address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  cache invalidate (same signal as cache `invalid`); suppresses a pending fill
- req_valid  in  1  pipeline request; a load is only presented on a cache miss
- req_load  in  1  1=load, 0=store
- req_addr  in  64  byte address
- req_size  in  3  [1:0]: 0=B, 1=H, 2=W, 3=D; [2]=1 means unsigned load
- req_mask  in  8  byte-enable mask before size masking
- req_wdata  in  64  store data, LSB-aligned
- stall  out  1  pipeline hold
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; bus error or timeout
- rdata  out  64  extended load result, valid with done
- bus_req_valid  out  1  bus request
- bus_req_ready  in  1  bus accepts the request
- bus_req_addr  out  64  {req_addr[63:3],3'b0}
- bus_req_write  out  1  1=write
- bus_req_wdata  out  64  req_wdata << (offset*8)
- bus_req_wstrb  out  8  (req_mask & size_mask) << offset
- bus_rsp_valid  in  1  response strobe
- bus_rsp_data  in  64  read data (aligned word)
- bus_rsp_err  in  1  response error
- update  out  1  cache update pulse
- update_load  out  1  1=fill, 0=invalidate (drives cache load_op during update)
- update_data  out  64  fill word

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers cleared. Reset mid-transaction returns to IDLE immediately and drops bus_req_valid. The bus must tolerate the abandoned transaction.
- States and transitions:
  - IDLE: on req_valid, latch addr/size/mask/wdata/load, assert stall, go to REQ. stall is also combinationally high in the cycle req_valid rises.
  - REQ: hold bus_req_valid and all request fields stable until bus_req_ready, then go to WAIT. A response in the same cycle as ready is not allowed.
  - WAIT: on bus_rsp_valid, latch data/err. On error, go to DONE with err=1. Otherwise go to FILL.
  - FILL: update=1 for exactly one cycle. A load gives update_load=1 and update_data=rsp word; a store gives update_load=0. If flush has occurred since REQ, skip the update on a load (update=0) but still complete. Go to DONE.
  - DONE: done=1 for one cycle, stall deasserts at the same edge, go to IDLE.
- A new req_valid is accepted no earlier than the cycle after DONE; req_valid while busy is ignored.
- Latency without wait states: request accepted in IDLE, then REQ(1), WAIT(n≥1), FILL(1), DONE(1). Minimum 4 cycles from accept to done.
- size_mask = {4{s1&s0},2{s1},s1|s0,1}; offset = addr[2:0]. Misaligned accesses that cross the word are truncated by the shift; no trap is raised here.
- rdata: tmp = rsp >> (offset*8). If req_size[2]=0, sign-extend from bit 7/15/31 per size[1:0]; otherwise zero-extend. D is passthrough. Store: rdata=0.
- Timeout: counter starts at entry to REQ and counts REQ+WAIT cycles. On reaching TIMEOUT_CYCLES, go to DONE with err=1, no update, and drop bus_req_valid.
- flush and FILL in the same cycle: flush wins and the fill is suppressed, so a stale line is never written after an invalidate.

Decomposition:
- Shared package dcache_pkg:
  - state enum {IDLE, REQ, WAIT, FILL, DONE};
  - size encodings SZ_B/H/W/D and the unsigned bit;
  - function size_mask();
  - function extend(tmp, size).
- One sub-module, dcache_extend: combinational shift-and-extend, reusable by the cache read path.

Test Plan:
- Load D at 0x1000, bus returns 0x1122334455667788 after 2 wait cycles -> one update pulse with update_load=1, update_data=0x1122334455667788; done with rdata=0x1122334455667788; stall high for 5 cycles.
- Load B signed at 0x1003, rsp 0x00000000_80FF0000 -> rdata=0xFFFFFFFFFFFFFF80 (byte 3=0x80); LBU (size=3'b100) -> 0x80.
- Store H, addr 0x2006, wdata 0xBEEF, mask 0xFF -> bus_req_addr=0x2000, wstrb=0xC0, wdata=0xBEEF000000000000, write=1; update pulse with update_load=0.
- bus_req_ready held low for 3 cycles -> bus_req_addr/wdata/wstrb stable throughout; bus_rsp_err=1 -> done with err=1, no update.
- flush asserted during WAIT on a load -> update stays 0; done=1, err=0, rdata still correct.
- TIMEOUT_CYCLES=8 with no response -> done with err=1 after 8 cycles, bus_req_valid=0; rst_n pulsed mid-WAIT -> all outputs 0 and next request accepted normally.
